dff_resp_checker: RTL and testbench
===================================

Name: dff_resp_checker

Overview:
Synthesizable response checker for a single D flip-flop under test. It is the receiving end of the flop stimulus sequence: it observes the DUT's D, reset and Q each clock, runs a reference flop model, and counts mismatches over a programmed window. It reports pass/fail, the error count and the cycle of the first failure. It sits beside dff_syn/dff_asyn-style DUTs in benches and on-chip self-test wrappers.

Parameters:
CNT_W, 16, width of the run-length, cycle and error counters
MODE, 0, reference model: 0 = synchronous-reset flop, 1 = asynchronous-reset flop
SETTLE, 1, cycles after start during which compares are suppressed (0..15)

Ports:
clk  input  1  checker and DUT clock, rising edge
reset  input  1  checker reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a check run; ignored while busy=1
run_len  input  CNT_W  number of compared cycles; sampled on the accepted start
dut_reset  input  1  DUT reset as driven to the DUT, active-high
dut_d  input  1  DUT D input as driven
dut_q  input  1  DUT Q output under observation
busy  output  1  high from the accepted start until done
done  output  1  one-cycle pulse at the end of a run
pass  output  1  1 when the last run had err_cnt==0; held until the next start
err_cnt  output  CNT_W  mismatches in the current/last run, saturating at all-ones
first_err_cyc  output  CNT_W  compare-cycle index (0-based) of the first mismatch
err_valid  output  1  first_err_cyc holds a captured value

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, pass, err_cnt, first_err_cyc and err_valid are all 0; the model register exp_q is 0; all counters are 0.
- State machine IDLE -> SETTLE -> CHECK -> DONE -> IDLE.
- IDLE: on start=1, latch run_len, clear err_cnt, err_valid, first_err_cyc and pass, and set busy=1.
  - If SETTLE=0, go to CHECK; otherwise go to SETTLE.
  - If the latched run_len=0, go directly to DONE.
- SETTLE: count SETTLE cycles; no compares are made. Then go to CHECK.
- CHECK: one compare per rising edge. cyc_cnt starts at 0; go to DONE after the compare where cyc_cnt==run_len-1.
- DONE (one cycle): done=1, busy=0, pass=(err_cnt==0), then IDLE. done is registered: it is high in the cycle after the last compare edge.
- Reference model runs every cycle in every state:
  - MODE 0: exp_q <= dut_reset ? 0 : dut_d.
  - MODE 1: exp_q <= dut_reset ? 0 : dut_d; the expected value at compare time is exp_cmp = dut_reset ? 0 : exp_q.
  - MODE 0: exp_cmp = exp_q.
- Compare: at each CHECK edge, mismatch = (dut_q != exp_cmp), using the values sampled just before that edge.
- On mismatch: err_cnt increments, saturating at 2^CNT_W-1. If err_valid=0, capture first_err_cyc=cyc_cnt and set err_valid=1.
- Latency: a DUT error at compare cycle k is visible on err_cnt one clock after edge k.
- start while busy: ignored; no restart, no state change.
- Checker reset mid-run: immediate return to IDLE with all outputs cleared. No done pulse and no partial result.
- dut_reset asserted during CHECK: not an error condition in itself; the model tracks it and compares continue.
- X/Z on dut_q: outside this block's scope. Behaviour follows the synthesizable != compare; benches must not rely on it.
- After DONE, err_cnt, first_err_cyc, err_valid and pass are held until the next accepted start.

Test Plan:
- MODE 0, SETTLE=1, run_len=8, DUT=sync flop, D toggles 0,1,0,1..., dut_reset=0 -> done after 1+8 cycles from start, pass=1, err_cnt=0, err_valid=0.
- MODE 0, run_len=6, DUT=async flop, dut_reset pulsed mid-cycle at compare index 3 with Q=1 -> Q clears before the edge, mismatch at index 3 -> err_cnt=1, first_err_cyc=3, pass=0.
- MODE 1, run_len=6, same async DUT and stimulus -> pass=1, err_cnt=0.
- MODE 0, CNT_W=4, run_len=15, dut_q stuck-at-1 with D=0 -> err_cnt saturates at 15, first_err_cyc=0, err_valid=1, done after 16 cycles.
- run_len=0 start -> busy for one cycle, done pulse, pass=1, err_cnt=0. A second start during busy in a run_len=10 run -> ignored, done only once, at the original time.
- Checker reset=0 at CHECK cycle 4 of a run_len=10 run with 2 errors logged -> all outputs 0 immediately. A fresh start then runs normally from cyc_cnt=0.

Source files
------------

// File: rtl/dff_resp_checker.sv
`default_nettype none
// dff_resp_checker: observes a flop under test against a reference flop model over a
// programmed compare window; reports pass/fail, saturating error count and first failing cycle.
// Revision: 1.0
module dff_resp_checker #(
  parameter int CNT_W  = 16,
  parameter int MODE   = 0,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] run_len,
  input  logic             dut_reset,
  input  logic             dut_d,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic             err_valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_ERR_MAX     = '1;
  localparam logic [CNT_W-1:0] c_ONE         = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       c_SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] first_q;
  logic [3:0]       settle_q;
  logic             exp_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             valid_q;

  logic             exp_cmp;
  logic             mismatch;
  logic             last_cmp;
  logic [CNT_W-1:0] err_d;

  // An async-reset flop already shows 0 while its reset is high, before any edge.
  assign exp_cmp  = (MODE == 1) ? (~dut_reset & exp_q) : exp_q;
  assign mismatch = (dut_q != exp_cmp);
  assign last_cmp = (cyc_q == (len_q - c_ONE));

  always_comb begin
    err_d = err_q;
    if ((state_q == S_CHECK) && mismatch && (err_q != c_ERR_MAX)) begin
      err_d = err_q + c_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cyc_q    <= '0;
      err_q    <= '0;
      first_q  <= '0;
      settle_q <= '0;
      exp_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      exp_q  <= ~dut_reset & dut_d;
      done_q <= 1'b0;
      err_q  <= err_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q    <= run_len;
            cyc_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            first_q  <= '0;
            valid_q  <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
            if (run_len == '0) begin
              state_q <= S_DONE;
            end else if (SETTLE == 0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          settle_q <= settle_q + 4'd1;
          if (settle_q == c_SETTLE_LAST) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          cyc_q <= cyc_q + c_ONE;
          if (mismatch && !valid_q) begin
            first_q <= cyc_q;
            valid_q <= 1'b1;
          end
          if (last_cmp) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_d == '0);
          end
        end
        S_DONE: begin
          // Still busy here only for a zero-length run, which reports one cycle late.
          if (busy_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            pass_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign first_err_cyc = first_q;
  assign err_valid     = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_resp_checker.sv
`default_nettype none
// tb_dff_resp_checker: drives modelled sync/async flops into three checker instances
// and compares every output against an ideal-flop reference.
// Revision: 1.0
module tb_dff_resp_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start;
  logic [15:0] run_len;
  logic        dut_reset, dut_d, flip, force1, sel_async;
  logic        sq, aq;
  wire         dut_q;

  logic [2:0]  busy_v, done_v, pass_v, valid_v;
  logic [15:0] err0, err1, first0, first1;
  logic [3:0]  err2, first2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Flops under test: one synchronous-reset, one asynchronous-reset.
  always_ff @(posedge clk) sq <= ~dut_reset & dut_d;
  always_ff @(posedge clk or posedge dut_reset) begin
    if (dut_reset) aq <= 1'b0;
    else           aq <= dut_d;
  end
  assign dut_q = force1 ? 1'b1 : ((sel_async ? aq : sq) ^ flip);

  dff_resp_checker #(.CNT_W(16), .MODE(0), .SETTLE(1)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .run_len(run_len),
    .dut_reset(dut_reset), .dut_d(dut_d), .dut_q(dut_q),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_cnt(err0), .first_err_cyc(first0), .err_valid(valid_v[0]));

  dff_resp_checker #(.CNT_W(16), .MODE(1), .SETTLE(0)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .run_len(run_len),
    .dut_reset(dut_reset), .dut_d(dut_d), .dut_q(dut_q),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_cnt(err1), .first_err_cyc(first1), .err_valid(valid_v[1]));

  dff_resp_checker #(.CNT_W(4), .MODE(0), .SETTLE(1)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .run_len(run_len[3:0]),
    .dut_reset(dut_reset), .dut_d(dut_d), .dut_q(dut_q),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_cnt(err2), .first_err_cyc(first2), .err_valid(valid_v[2]));

  function automatic int settle_of(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int mode_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int max_of(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  function automatic logic [15:0] get_err(input int i);
    case (i)
      0:       return err0;
      1:       return err1;
      default: return {12'd0, err2};
    endcase
  endfunction

  function automatic logic [15:0] get_first(input int i);
    case (i)
      0:       return first0;
      1:       return first1;
      default: return {12'd0, first2};
    endcase
  endfunction

  // Returns {force1, flip, dut_reset, dut_d} for the edge of compare index k.
  function automatic logic [3:0] stim(input int kind, input int k);
    logic d, r, f, s;
    d = k[0]; r = 1'b0; f = 1'b0; s = 1'b0;
    case (kind)
      1: begin d = 1'b1; r = (k == 3); end
      2: begin d = 1'b0; s = 1'b1; end
      3: begin
        d = ($urandom_range(0, 1) == 1);
        r = ($urandom_range(0, 7) == 0);
        f = ($urandom_range(0, 5) == 0);
      end
      4: f = (k == 1) || (k == 2);
      5: begin
        d = ($urandom_range(0, 1) == 1);
        r = ($urandom_range(0, 3) == 0);
        f = ($urandom_range(0, 1) == 1);
      end
      default: ;
    endcase
    return {s, f, r, d};
  endfunction

  task automatic run_check(input int inst, input int len, input int kind,
                           input logic async_dut, input int restart_e, input int abort_k);
    int   s, done_e, m_err, m_first, k;
    logic m_valid, last_d, last_r, e_exp, e_cmp;
    s = settle_of(inst);
    done_e = (len == 0) ? 1 : s + len;
    m_err = 0; m_first = 0; m_valid = 1'b0; last_d = 1'b0; last_r = 1'b0;
    sel_async = async_dut;
    run_len = 16'(len);
    for (int e = 0; e <= done_e + 1; e++) begin
      k = e - 1 - s;
      {force1, flip, dut_reset, dut_d} = stim(kind, k);
      start = 3'b000;
      if (e == 0 || e == restart_e) start[inst] = 1'b1;
      if (abort_k >= 0 && k == abort_k) begin
        reset = 1'b0;
        #1;
        n_chk++;
        if ({busy_v[inst], done_v[inst], pass_v[inst], valid_v[inst]} !== 4'b0000)
          $display("FAIL abort_flags inst=%0d got=%b exp=0000", inst,
                   {busy_v[inst], done_v[inst], pass_v[inst], valid_v[inst]});
        else n_pass++;
        n_chk++;
        if (get_err(inst) !== 16'd0 || get_first(inst) !== 16'd0)
          $display("FAIL abort_counts inst=%0d err=%0d first=%0d exp=0/0", inst,
                   get_err(inst), get_first(inst));
        else n_pass++;
        start = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      #4;
      if (k >= 0 && k < len) begin
        // Ideal flop: Q follows the D of the previous edge unless reset was high there.
        e_exp = last_r ? 1'b0 : last_d;
        e_cmp = (mode_of(inst) == 1 && dut_reset) ? 1'b0 : e_exp;
        if (dut_q !== e_cmp) begin
          if (m_err < max_of(inst)) m_err++;
          if (!m_valid) begin m_valid = 1'b1; m_first = k; end
        end
      end
      last_d = dut_d;
      last_r = dut_reset;
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (busy_v[inst] !== (e < done_e))
        $display("FAIL busy inst=%0d e=%0d got=%b exp=%b", inst, e, busy_v[inst], (e < done_e));
      else n_pass++;
      n_chk++;
      if (done_v[inst] !== (e == done_e))
        $display("FAIL done inst=%0d e=%0d got=%b exp=%b", inst, e, done_v[inst], (e == done_e));
      else n_pass++;
      n_chk++;
      if (get_err(inst) !== 16'(m_err))
        $display("FAIL err_cnt inst=%0d e=%0d got=%0d exp=%0d", inst, e, get_err(inst), m_err);
      else n_pass++;
    end
    start = 3'b000;
    n_chk++;
    if (pass_v[inst] !== (m_err == 0))
      $display("FAIL pass inst=%0d got=%b exp=%b", inst, pass_v[inst], (m_err == 0));
    else n_pass++;
    n_chk++;
    if (valid_v[inst] !== m_valid)
      $display("FAIL err_valid inst=%0d got=%b exp=%b", inst, valid_v[inst], m_valid);
    else n_pass++;
    n_chk++;
    if (get_first(inst) !== (m_valid ? 16'(m_first) : 16'd0))
      $display("FAIL first_err_cyc inst=%0d got=%0d exp=%0d", inst, get_first(inst),
               m_valid ? m_first : 0);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 3'b000; run_len = 16'd0;
    dut_reset = 1'b0; dut_d = 1'b0; flip = 1'b0; force1 = 1'b0; sel_async = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({busy_v[i], done_v[i], pass_v[i], valid_v[i]} !== 4'b0000)
        $display("FAIL reset_flags inst=%0d got=%b exp=0000", i,
                 {busy_v[i], done_v[i], pass_v[i], valid_v[i]});
      else n_pass++;
      n_chk++;
      if (get_err(i) !== 16'd0 || get_first(i) !== 16'd0)
        $display("FAIL reset_counts inst=%0d err=%0d first=%0d exp=0/0", i, get_err(i), get_first(i));
      else n_pass++;
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sync_toggle();
    run_check(0, 8, 0, 1'b0, -1, -1);
    n_chk++;
    if ({pass_v[0], valid_v[0]} !== 2'b10 || err0 !== 16'd0)
      $display("FAIL sync_toggle pass=%b valid=%b err=%0d exp=1/0/0", pass_v[0], valid_v[0], err0);
    else n_pass++;
  endtask

  task automatic test_async_mode0();
    run_check(0, 6, 1, 1'b1, -1, -1);
    n_chk++;
    if (err0 !== 16'd1 || first0 !== 16'd3 || pass_v[0] !== 1'b0)
      $display("FAIL async_mode0 err=%0d first=%0d pass=%b exp=1/3/0", err0, first0, pass_v[0]);
    else n_pass++;
  endtask

  task automatic test_async_mode1();
    run_check(1, 6, 1, 1'b1, -1, -1);
    n_chk++;
    if (err1 !== 16'd0 || pass_v[1] !== 1'b1)
      $display("FAIL async_mode1 err=%0d pass=%b exp=0/1", err1, pass_v[1]);
    else n_pass++;
  endtask

  task automatic test_saturate();
    run_check(2, 15, 2, 1'b0, -1, -1);
    n_chk++;
    if (err2 !== 4'd15 || first2 !== 4'd0 || valid_v[2] !== 1'b1)
      $display("FAIL saturate err=%0d first=%0d valid=%b exp=15/0/1", err2, first2, valid_v[2]);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    run_check(0, 0, 0, 1'b0, -1, -1);
    n_chk++;
    if (pass_v[0] !== 1'b1 || err0 !== 16'd0)
      $display("FAIL zero_len pass=%b err=%0d exp=1/0", pass_v[0], err0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_check(0, 10, 3, 1'b0, 4, -1);
  endtask

  task automatic test_reset_midrun();
    run_check(0, 10, 4, 1'b0, -1, 4);
    run_check(0, 10, 4, 1'b0, -1, -1);
    n_chk++;
    if (err0 !== 16'd2 || first0 !== 16'd1)
      $display("FAIL reset_midrun_rerun err=%0d first=%0d exp=2/1", err0, first0);
    else n_pass++;
  endtask

  task automatic test_random();
    int inst, len;
    for (int n = 0; n < 12; n++) begin
      inst = $urandom_range(0, 2);
      len  = (inst == 2) ? $urandom_range(1, 15) : $urandom_range(1, 20);
      run_check(inst, len, ($urandom_range(0, 1) == 1) ? 3 : 5,
                ($urandom_range(0, 1) == 1), -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_sync_toggle();
    test_async_mode0();
    test_async_mode1();
    test_saturate();
    test_zero_len();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
